// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver, with level, sticky overrun and idle timeout.
// Optional idle-timeout counter is built only when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int                     DEPTH_LOG2     = 4,
  parameter int                     TIMEOUT_W      = 16,
  parameter logic [TIMEOUT_W-1:0]   TIMEOUT_CYCLES = 16'd3472
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  m_valid,
  output logic [7:0]            m_data,
  input  logic                  m_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overrun,
  input  logic                  clr_overrun,
  output logic                  timeout
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overrun_q, overrun_d;

  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic drop;

  always_comb begin
    full    = (level_q == FULL_LEVEL);
    empty   = (level_q == '0);
    pop     = !empty && m_ready;
    // A full FIFO can still take a byte when the head leaves on the same edge.
    push_ok = in_valid && (!full || pop);
    drop    = in_valid && full && !pop;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // A drop in the same cycle as a clear must leave the flag set.
  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    m_valid = !empty;
    m_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    level   = level_q;
    overrun = overrun_q;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] idle_q, idle_d;

  // Any receiver strobe or consumer pop counts as activity and restarts the idle count.
  always_comb begin
    idle_d = idle_q;
    if (in_valid || pop || empty) begin
      idle_d = '0;
    end else if (idle_q != TIMEOUT_CYCLES) begin
      idle_d = idle_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign timeout = (idle_q == TIMEOUT_CYCLES) && !empty;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH_LOG2=4, TIMEOUT_CYCLES=8).
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic [4:0] level;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  logic       timeout;

  int n_checks = 0;
  int n_fails  = 0;

  uart_rx_fifo #(
    .DEPTH_LOG2    (4),
    .TIMEOUT_W     (16),
    .TIMEOUT_CYCLES(16'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .level      (level),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_m_valid got %b exp 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fails++; $display("[TB] FAIL reset_m_data got %h exp 00", m_data); end
    n_checks++; if (level !== 5'd0) begin n_fails++; $display("[TB] FAIL reset_level got %0d exp 0", level); end
    n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_overrun got %b exp 0", overrun); end
    n_checks++; if (timeout !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_timeout got %b exp 0", timeout); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'hA5;
    n_checks++; if (m_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL single_no_bypass got %b exp 0", m_valid); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (m_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL single_m_valid got %b exp 1", m_valid); end
    n_checks++; if (m_data !== 8'hA5) begin n_fails++; $display("[TB] FAIL single_m_data got %h exp a5", m_data); end
    n_checks++; if (level !== 5'd1) begin n_fails++; $display("[TB] FAIL single_level got %0d exp 1", level); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL single_pop_valid got %b exp 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fails++; $display("[TB] FAIL single_pop_data got %h exp 00", m_data); end
    n_checks++; if (level !== 5'd0) begin n_fails++; $display("[TB] FAIL single_pop_level got %0d exp 0", level); end
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (level !== 5'd16) begin n_fails++; $display("[TB] FAIL fill_level got %0d exp 16", level); end
    n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("[TB] FAIL fill_overrun got %b exp 0", overrun); end
    in_valid = 1'b1; in_data = 8'h10;
    tick();
    in_valid = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("[TB] FAIL drop_overrun got %b exp 1", overrun); end
    n_checks++; if (level !== 5'd16) begin n_fails++; $display("[TB] FAIL drop_level got %0d exp 16", level); end
    n_checks++; if (m_data !== 8'h00) begin n_fails++; $display("[TB] FAIL drop_head got %h exp 00", m_data); end
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (m_valid !== 1'b1 || m_data !== 8'(i)) begin n_fails++; $display("[TB] FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, 8'(i)); end
      tick();
    end
    m_ready = 1'b0;
    n_checks++; if (m_valid !== 1'b0 || level !== 5'd0) begin n_fails++; $display("[TB] FAIL drain_empty got v=%b lvl=%0d exp v=0 lvl=0", m_valid, level); end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("[TB] FAIL clr_after_drain got %b exp 0", overrun); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'h20 + 8'(i);
      tick();
    end
    in_valid = 1'b1; in_data = 8'h55; m_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (level !== 5'd16) begin n_fails++; $display("[TB] FAIL fullpp_level got %0d exp 16", level); end
    n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("[TB] FAIL fullpp_overrun got %b exp 0", overrun); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == 15) ? 8'h55 : 8'h21 + 8'(i);
      n_checks++; if (m_data !== exp_b) begin n_fails++; $display("[TB] FAIL fullpp_drain_%0d got %h exp %h", i, m_data, exp_b); end
      tick();
    end
    m_ready = 1'b0;
    n_checks++; if (level !== 5'd0) begin n_fails++; $display("[TB] FAIL fullpp_empty got %0d exp 0", level); end
  endtask

  task automatic test_clr_overrun();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i);
      tick();
    end
    n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("[TB] FAIL clr_setup got %b exp 1", overrun); end
    clr_overrun = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("[TB] FAIL clr_vs_drop got %b exp 1", overrun); end
    tick();
    clr_overrun = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("[TB] FAIL clr_alone got %b exp 0", overrun); end
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    m_ready = 1'b0;
    n_checks++; if (level !== 5'd0) begin n_fails++; $display("[TB] FAIL clr_drain got %0d exp 0", level); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    int popped;
    int c;
    popped = 0;
    c = 0;
    while ((c < 40 || q.size() != 0) && c < 120) begin
      bit exp_v;
      in_valid = (c < 40);
      in_data  = 8'h40 + 8'(c);
      m_ready  = (c >= 40) || (c % 4 != 3);
      exp_v    = (q.size() != 0);
      n_checks++; if (m_valid !== exp_v) begin n_fails++; $display("[TB] FAIL wrap_valid_c%0d got %b exp %b", c, m_valid, exp_v); end
      if (exp_v && m_ready) begin
        n_checks++; if (m_data !== q[0]) begin n_fails++; $display("[TB] FAIL wrap_data_%0d got %h exp %h", popped, m_data, q[0]); end
        void'(q.pop_front());
        popped++;
      end
      if (in_valid) q.push_back(in_data);
      tick();
      c++;
    end
    in_valid = 1'b0; m_ready = 1'b0;
    n_checks++; if (popped != 40) begin n_fails++; $display("[TB] FAIL wrap_count got %0d exp 40", popped); end
    n_checks++; if (level !== 5'd0) begin n_fails++; $display("[TB] FAIL wrap_level got %0d exp 0", level); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h70 + 8'(i);
      tick();
    end
    rst = 1'b1; in_data = 8'h99;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (level !== 5'd0) begin n_fails++; $display("[TB] FAIL rstmid_level got %0d exp 0", level); end
    n_checks++; if (m_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rstmid_valid got %b exp 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fails++; $display("[TB] FAIL rstmid_data got %h exp 00", m_data); end
  endtask

  task automatic test_timeout();
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    n_checks++; if (timeout !== 1'b0) begin n_fails++; $display("[TB] FAIL to_after_push got %b exp 0", timeout); end
    for (int k = 1; k <= 10; k++) begin
      logic exp_t;
      tick();
      exp_t = TO_EN && (k >= 8);
      n_checks++; if (timeout !== exp_t) begin n_fails++; $display("[TB] FAIL to_idle_%0d got %b exp %b", k, timeout, exp_t); end
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    n_checks++; if (timeout !== 1'b0 || m_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL to_after_pop got t=%b v=%b exp t=0 v=0", timeout, m_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overrun();
    test_full_push_pop();
    test_clr_overrun();
    test_wrap();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
